spy_uart_core: RTL
==================

// Module: spy_uart_core
// PURPOSE
//  8N1 UART serving the spy port. Serial link to host on rs232 pins.
//  Parallel side uses four-phase req/ack handshakes for RX and TX, one byte buffered each way.
//  Sits directly below the spy port: feeds it received command nibble-bytes, sends its response bytes.
// PARAMETERS
//  DIV      434  clk cycles per bit (50 MHz / 115200); must be >= 4
//  DIV_W    10   width of bit-period counter; must hold DIV-1
// PORTS
//  clk           in   1  clock
//  reset         in   1  synchronous, active-high
//  tx_data       in   8  byte to send; sampled on load acceptance
//  ld_tx_req     in   1  load request (four-phase)
//  ld_tx_ack     out  1  load acknowledge
//  tx_enable     in   1  permits a new frame to start
//  tx_empty      out  1  1 = TX holding register free and line idle
//  tx_out        out  1  serial out, idle high
//  rx_in         in   1  serial in, asynchronous
//  rx_enable     in   1  permits detection of a new start bit
//  rx_req        in   1  read request (four-phase)
//  rx_ack        out  1  read acknowledge
//  rx_data       out  8  buffered received byte, stable while rx_empty=0
//  rx_empty      out  1  1 = no unread byte
//  rx_overrun    out  1  1-cycle pulse: completed byte discarded, buffer full
//  rx_frame_err  out  1  1-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset: tx_out=1, tx_empty=1, ld_tx_ack=0, rx_ack=0, rx_empty=1, rx_data=0, pulses=0.
//  Reset aborts any frame; all FSMs go to IDLE.
//  TX load:
//    - ld_tx_req & tx_empty & ~ld_tx_ack: latch tx_data, then next cycle ld_tx_ack=1 and tx_empty=0.
//    - Request while ~tx_empty: held, no ack.
//    - ld_tx_ack drops the cycle after ld_tx_req is seen low.
//  TX FSM: T_IDLE -> T_START -> T_DATA -> T_STOP -> T_IDLE.
//    - Leaves T_IDLE when the byte is loaded and tx_enable=1; otherwise holds.
//    - Start bit is DIV cycles low; data is 8 bits LSB first, DIV cycles each; stop bit is DIV cycles high.
//    - tx_empty=1 in the cycle after the stop bit ends. Frame = 10*DIV cycles.
//    - tx_enable dropping mid-frame does not abort; the frame completes.
//  RX sync: rx_in passes through a 2-flop synchroniser (rxs); 2-cycle input latency.
//  RX FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE (R_WAITHI on framing error).
//    - R_IDLE: when rx_enable & rxs==0, go to R_START.
//    - R_START: count DIV/2 and resample. If rxs==1, treat as a glitch: return to R_IDLE, report nothing.
//    - R_DATA: sample every DIV cycles (mid-bit), 8 bits, LSB first.
//    - R_STOP: sample after DIV.
//        * rxs==1 and buffer free: rx_data=byte, rx_empty=0.
//        * rxs==1 and buffer full: byte dropped, rx_overrun pulse, old rx_data kept.
//        * rxs==0: rx_frame_err pulse, byte dropped, go to R_WAITHI until rxs==1.
//    - rx_enable dropping mid-frame does not abort.
//  RX read:
//    - rx_req & ~rx_empty & ~rx_ack: next cycle rx_ack=1. rx_data stays stable.
//    - rx_ack=1 & ~rx_req: next cycle rx_ack=0 and rx_empty=1.
//    - rx_req while rx_empty: held, no ack.
//  Simultaneous: a release (rx_ack falling) in the same cycle as R_STOP completion frees the slot.
//    The new byte is stored: rx_empty stays 0, no overrun.
//  Simultaneous TX load request and end of stop bit: load is accepted one cycle after tx_empty=1.
// STRUCTURE
//  Shared include spy_uart_defs.vh: TX/RX state encodings, frame length (10 bits), data width 8.
//  One sub-module is natural: spy_uart_rx. It contains the synchroniser, RX FSM, buffer and handshake.
//  TX FSM and load handshake stay inline.
// TESTING (bench uses DIV=4)
//  1. Reset mid-TX-frame -> tx_out=1, tx_empty=1 next cycle; no further edges on tx_out.
//  2. Send 0x35 via req/ack:
//     -> ld_tx_ack 1 cycle after req.
//     -> tx_out: 0 x4, then 1,0,1,0,1,1,0,0 x4 each, then 1 x4.
//     -> tx_empty=1 40 cycles after frame start.
//  3. Drive 0xA3 frame on rx_in -> rx_empty falls after R_STOP; req/ack returns rx_data=0xA3.
//     -> rx_empty=1 one cycle after req drops.
//  4. Frames 0x11 then 0x22, no read -> one rx_overrun pulse; read returns 0x11.
//  5. Frame 0x5A with stop bit low -> rx_frame_err pulse; rx_empty stays 1.
//     -> Next good frame 0x0F is received.
//  6. 1-cycle low glitch on rx_in, and tx_enable=0 with loaded byte.
//     -> no RX byte; tx_out stays 1 until tx_enable=1, then frame starts.

Source files
------------

// File: rtl/spy_uart_core_pkg.sv
// Shared definitions for the spy-port UART: frame geometry and FSM state encodings.
package spy_uart_core_pkg;

  localparam int unsigned DataW     = 8;
  localparam int unsigned FrameBits = 10;  // start + 8 data + stop

  typedef enum logic [1:0] {
    TIdle,
    TStart,
    TData,
    TStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RIdle,
    RStart,
    RData,
    RStop,
    RWaitHi
  } rx_state_e;

endpackage

// File: rtl/spy_uart_rx.sv
// UART receiver: input synchroniser, 8N1 RX FSM, one-byte buffer and four-phase read handshake.
module spy_uart_rx
  import spy_uart_core_pkg::*;
#(
  parameter int unsigned DIV   = 434,
  parameter int unsigned DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic             rx_enable,
  input  logic             rx_req,
  output logic             rx_ack,
  output logic [DataW-1:0] rx_data,
  output logic             rx_empty,
  output logic             rx_overrun,
  output logic             rx_frame_err
);

  localparam logic [DIV_W-1:0] DivLast  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] HalfLast = DIV_W'(DIV / 2 - 1);

  logic             rx_meta_q, rxs_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [DataW-1:0] shift_q, shift_d;
  logic [DataW-1:0] data_q, data_d;
  logic             empty_q, empty_d;
  logic             ack_q, ack_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             release_rd;

  // Two-flop synchroniser on the asynchronous serial input, idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  // State register for the RX FSM, buffer and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: read handshake first, then frame completion may refill the slot it frees.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    empty_d    = empty_q;
    ack_d      = ack_q;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    release_rd = ack_q & ~rx_req;

    if (rx_req & ~empty_q & ~ack_q) begin
      ack_d = 1'b1;
    end else if (release_rd) begin
      ack_d   = 1'b0;
      empty_d = 1'b1;
    end

    unique case (state_q)
      RIdle: begin
        if (rx_enable && !rxs_q) begin
          state_d = RStart;
          cnt_d   = '0;
        end
      end
      RStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d = rxs_q ? RIdle : RData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RData: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DataW-1:1]};
          if (bit_q == 3'(DataW - 1)) begin
            state_d = RStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RStop: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = RIdle;
            if (empty_q || release_rd) begin
              data_d  = shift_q;
              empty_d = 1'b0;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = RWaitHi;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RWaitHi: begin
        if (rxs_q) begin
          state_d = RIdle;
        end
      end
      default: state_d = RIdle;
    endcase
  end

  assign rx_ack       = ack_q;
  assign rx_data      = data_q;
  assign rx_empty     = empty_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/spy_uart_core.sv
// 8N1 UART for the spy port: inline TX FSM with load handshake, RX in spy_uart_rx.
module spy_uart_core
  import spy_uart_core_pkg::*;
#(
  parameter int unsigned DIV   = 434,
  parameter int unsigned DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DataW-1:0] tx_data,
  input  logic             ld_tx_req,
  output logic             ld_tx_ack,
  input  logic             tx_enable,
  output logic             tx_empty,
  output logic             tx_out,
  input  logic             rx_in,
  input  logic             rx_enable,
  input  logic             rx_req,
  output logic             rx_ack,
  output logic [DataW-1:0] rx_data,
  output logic             rx_empty,
  output logic             rx_overrun,
  output logic             rx_frame_err
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV - 1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [DataW-1:0] shift_q, shift_d;
  logic             empty_q, empty_d;
  logic             ack_q, ack_d;

  // State register for the TX FSM and load handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      empty_q <= empty_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state: load only while empty (FSM idle), so the shift register is never live then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    empty_d = empty_q;
    ack_d   = ack_q;

    if (ld_tx_req && empty_q && !ack_q) begin
      ack_d   = 1'b1;
      empty_d = 1'b0;
      shift_d = tx_data;
    end else if (ack_q && !ld_tx_req) begin
      ack_d = 1'b0;
    end

    unique case (state_q)
      TIdle: begin
        if (!empty_q && tx_enable) begin
          state_d = TStart;
          cnt_d   = '0;
        end
      end
      TStart: begin
        if (cnt_q == DivLast) begin
          state_d = TData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TData: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[DataW-1:1]};
          if (bit_q == 3'(DataW - 1)) begin
            state_d = TStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TStop: begin
        if (cnt_q == DivLast) begin
          state_d = TIdle;
          cnt_d   = '0;
          empty_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TIdle;
    endcase
  end

  // Serial output decoded from the FSM; idle and stop are both high.
  always_comb begin
    tx_out = 1'b1;
    unique case (state_q)
      TStart:  tx_out = 1'b0;
      TData:   tx_out = shift_q[0];
      default: tx_out = 1'b1;
    endcase
  end

  assign tx_empty  = empty_q;
  assign ld_tx_ack = ack_q;

  spy_uart_rx #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_enable    (rx_enable),
    .rx_req       (rx_req),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

endmodule
